// File: rtl/bcd_to_bin_pkg.sv
// Shared board-I/O constants for the BCD-to-binary converter: state encodings, widths, digit helper.
package bcd_to_bin_pkg;

  localparam int unsigned BIN_W = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A nibble above 9 is not a decimal digit.
  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake and data bus between a launcher and the BCD-to-binary converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 8
);
  import bcd_to_bin_pkg::*;

  logic                 start;
  logic [4*DIGITS-1:0]  bcd_in;
  logic                 busy;
  logic                 done;
  logic [BIN_W-1:0]     bin_out;
  logic                 err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + digit.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_bin_if.slave   bus
);

  localparam int unsigned SR_W = 4 * DIGITS;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_acc_q, err_acc_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        digit;
  logic              launch;

  assign digit = sr_q[SR_W-1 -: 4];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
    launch    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        launch = bus.start;
      end
      S_RUN: begin
        acc_d     = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
        err_acc_d = err_acc_q | digit_bad(digit);
        sr_d      = sr_q << 4;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          bin_d   = acc_d;
          err_d   = err_acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        launch  = bus.start;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // IDLE and DONE share the same launch actions, allowing back-to-back conversions
    if (launch) begin
      sr_d      = bus.bcd_in;
      acc_d     = '0;
      cnt_d     = '0;
      err_acc_d = 1'b0;
      state_d   = S_RUN;
    end
  end

  assign busy_d = (state_d == S_RUN);
  assign done_d = (state_d == S_DONE);

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=8) with a bin-to-BCD round-trip sweep.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bcd_to_bin_if #(.DIGITS(DIGITS)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Launch one conversion and observe 12 cycles; optionally re-pulse start mid-RUN.
  task automatic convert(input string tag, input logic [31:0] bcd, input logic [31:0] exp_bin,
                         input logic exp_err, input logic repulse);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (repulse && n == 3) begin
        bus.start  = 1'b1;
        bus.bcd_in = 32'h9999_9999;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = n;
        chk({tag, "_bin"}, bus.bin_out, exp_bin);
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      end
    end
    chk({tag, "_done_at"}, 32'(done_at), 32'd9);
    chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    chk({tag, "_busy_cnt"}, 32'(busy_n), 32'd8);
    chk({tag, "_hold"}, bus.bin_out, exp_bin);
  endtask

  initial begin
    int done_n;
    int d1;
    int d2;
    logic [31:0] v;
    n_tests    = 0;
    n_fail     = 0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    rst        = 1'b1;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bin", bus.bin_out, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    convert("nom", 32'h0000_1234, 32'd1234, 1'b0, 1'b0);
    convert("max", 32'h9999_9999, 32'h05F5_E0FF, 1'b0, 1'b0);
    convert("zero", 32'h0000_0000, 32'd0, 1'b0, 1'b0);
    convert("bad", 32'h0000_001A, 32'd20, 1'b1, 1'b0);
    convert("after_bad", 32'h0000_0005, 32'd5, 1'b0, 1'b0);
    convert("all_f", 32'hFFFF_FFFF, 32'd166666665, 1'b1, 1'b0);
    convert("repulse", 32'h0000_1234, 32'd1234, 1'b0, 1'b1);

    // start held through DONE: second conversion with no IDLE gap
    done_n = 0;
    d1     = -1;
    d2     = -1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 32'h0000_0077;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 10) begin
        chk("b2b_busy_gap", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_n++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
        chk("b2b_bin", bus.bin_out, 32'd77);
      end
    end
    chk("b2b_d1", 32'(d1), 32'd9);
    chk("b2b_d2", 32'(d2), 32'd18);
    chk("b2b_cnt", 32'(done_n), 32'd2);

    // async reset in the middle of a conversion
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 32'h0000_0031;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_bin", bus.bin_out, 32'd0);
    chk("mid_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    done_n = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_n++;
    end
    chk("mid_no_done", 32'(done_n), 32'd0);
    convert("post_rst", 32'h0000_0042, 32'd42, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      v = 32'($urandom_range(99999999, 0));
      convert("rt", to_bcd(v), v, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
